// File: rtl/add_mop_seq_ctrl_if.sv
// rtl/add_mop_seq_ctrl_if.sv - operand and result stream bundle for add_mop_seq_ctrl
//
// Purpose: groups the operand input stream and the result output stream of
// add_mop_seq_ctrl into a single interface. Signal suffixes are taken from
// the controller's point of view.
//
// Signals:
//   op_valid_i   operand beat valid (producer -> controller)
//   op_ready_o   operand beat accepted when high with op_valid_i
//   op_data_i    lanes*width operand bits, lane k at [k*width +: width]
//   res_valid_o  result valid (controller -> consumer)
//   res_ready_i  result consumed when high with res_valid_o
//   res_o        width-bit result
//
// Modports:
//   slave   controller side (add_mop_seq_ctrl)
//   master  operand producer / result consumer side

interface add_mop_seq_ctrl_if #(
    parameter int width = 16,
    parameter int lanes = 2
) ();

    logic                     op_valid_i;
    logic                     op_ready_o;
    logic [lanes*width-1:0]   op_data_i;
    logic                     res_valid_o;
    logic                     res_ready_i;
    logic [width-1:0]         res_o;

    modport slave (
        input  op_valid_i,
        input  op_data_i,
        output op_ready_o,
        output res_valid_o,
        input  res_ready_i,
        output res_o
    );

    modport master (
        output op_valid_i,
        output op_data_i,
        input  op_ready_o,
        input  res_valid_o,
        output res_ready_i,
        input  res_o
    );

endinterface

// File: rtl/add_mop_seq_ctrl.sv
// rtl/add_mop_seq_ctrl.sv - sequential multi-operand carry-save accumulator controller
//
// Purpose: accepts a job of count_i operand beats, each beat carrying `lanes`
// operands, and folds every beat into a carry-save pair (s_q, c_q) with one
// combinational compressor of depth lanes+2. After the last beat a single
// carry-propagate add produces the modulo-2^width result, which is held on a
// valid/ready output until consumed. All arithmetic wraps mod 2^width.
//
// Parameters:
//   width      operand/result width in bits
//   lanes      operands per beat (2 or more)
//   cnt_width  width of the remaining-beat counter
//
// Ports:
//   clk_i      clock
//   rst_i      synchronous active-high reset
//   start_i    start a job (sampled only in IDLE)
//   count_i    number of beats in the job (sampled with start_i)
//   abort_i    drop the current job (only with ADD_MOP_SEQ_ABORT_EN)
//   busy_o     high whenever the controller is not in IDLE
//   bus        operand/result streams (add_mop_seq_ctrl_if.slave)
//
// Build option:
//   ADD_MOP_SEQ_ABORT_EN  adds abort_i; abort in ACCUM or RESOLVE returns to
//                         IDLE without producing a result.

// Carry-save compressor: reduces `depth` operands to a sum/carry pair whose
// arithmetic sum equals the sum of all operands mod 2^width. Built as a
// linear chain of 3:2 compressors; the carry out of the MSB is dropped.
module add_mop_csv #(
    parameter int width = 16,
    parameter int depth = 4
) (
    input  logic [depth*width-1:0] ops_i,
    output logic [width-1:0]       sum_o,
    output logic [width-1:0]       carry_o
);

    logic [width-1:0] s_v;
    logic [width-1:0] c_v;
    logic [width-1:0] x_v;
    logic [width-1:0] maj_v;

    always_comb begin
        s_v   = ops_i[0 +: width];
        c_v   = ops_i[width +: width];
        x_v   = '0;
        maj_v = '0;
        for (int k = 2; k < depth; k++) begin
            x_v   = ops_i[k*width +: width];
            maj_v = (s_v & c_v) | (s_v & x_v) | (c_v & x_v);
            s_v   = s_v ^ c_v ^ x_v;
            // Shifting the majority vector left discards the MSB carry,
            // which is exactly the mod 2^width wrap.
            c_v   = maj_v << 1;
        end
        sum_o   = s_v;
        carry_o = c_v;
    end

endmodule

module add_mop_seq_ctrl #(
    parameter int width     = 16,
    parameter int lanes     = 2,
    parameter int cnt_width = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [cnt_width-1:0] count_i,
`ifdef ADD_MOP_SEQ_ABORT_EN
    input  logic                 abort_i,
`endif
    output logic                 busy_o,
    add_mop_seq_ctrl_if.slave    bus
);

    localparam int depth = lanes + 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t               state_q;
    logic [width-1:0]     s_q;
    logic [width-1:0]     c_q;
    logic [width-1:0]     res_q;
    logic [cnt_width-1:0] cnt_q;
    logic                 op_ready_q;
    logic                 res_valid_q;
    logic                 busy_q;

    // Next carry-save pair for the beat currently on the bus.
    logic [width-1:0]     s_d;
    logic [width-1:0]     c_d;
    logic                 beat_fire;
    logic                 abort_hit;

    add_mop_csv #(
        .width (width),
        .depth (depth)
    ) u_csv (
        .ops_i   ({c_q, s_q, bus.op_data_i}),
        .sum_o   (s_d),
        .carry_o (c_d)
    );

`ifdef ADD_MOP_SEQ_ABORT_EN
    // Abort only has an effect while a job is being accumulated or resolved.
    assign abort_hit = abort_i && ((state_q == ACCUM) || (state_q == RESOLVE));
    // A beat in the abort cycle must not be consumed, so ready is masked.
    assign bus.op_ready_o = op_ready_q & ~abort_hit;
`else
    assign abort_hit      = 1'b0;
    assign bus.op_ready_o = op_ready_q;
`endif

    assign beat_fire       = bus.op_valid_i & bus.op_ready_o;
    assign bus.res_valid_o = res_valid_q;
    assign bus.res_o       = res_q;
    assign busy_o          = busy_q;

    // Single FSM process. The output flags are registered alongside the
    // state so that each one is high exactly when the matching state is.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            s_q         <= '0;
            c_q         <= '0;
            res_q       <= '0;
            cnt_q       <= '0;
            op_ready_q  <= 1'b0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else if (abort_hit) begin
            state_q     <= IDLE;
            s_q         <= '0;
            c_q         <= '0;
            cnt_q       <= '0;
            op_ready_q  <= 1'b0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        s_q    <= '0;
                        c_q    <= '0;
                        busy_q <= 1'b1;
                        if (count_i != '0) begin
                            cnt_q      <= count_i;
                            state_q    <= ACCUM;
                            op_ready_q <= 1'b1;
                        end else begin
                            // Empty job: resolve the cleared state straight away.
                            state_q <= RESOLVE;
                        end
                    end
                end

                ACCUM: begin
                    if (beat_fire) begin
                        s_q   <= s_d;
                        c_q   <= c_d;
                        cnt_q <= cnt_q - cnt_width'(1);
                        if (cnt_q == cnt_width'(1)) begin
                            state_q    <= RESOLVE;
                            op_ready_q <= 1'b0;
                        end
                    end
                end

                RESOLVE: begin
                    res_q       <= s_q + c_q;
                    state_q     <= DONE;
                    res_valid_q <= 1'b1;
                end

                DONE: begin
                    if (bus.res_ready_i) begin
                        state_q     <= IDLE;
                        res_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end

                default: begin
                    state_q     <= IDLE;
                    op_ready_q  <= 1'b0;
                    res_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

endmodule
